// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg: shared state type, line level and parity helper for the FIFO-draining UART transmitter
package fifo_uart_pkg;
  typedef enum logic [2:0] {IDLE, SETTLE, START, DATA, PARITY, STOP} state_t;
  localparam logic TX_IDLE_LEVEL = 1'b1;
  function automatic logic even_parity(input logic [31:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: wrapping bit-period counter with synchronous clear and an end-of-bit tick
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic bit_done
);
  localparam int DIV_W = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  logic [DIV_W-1:0] cnt;
  assign bit_done = cnt == DIV_W'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk)
    if (!reset_n || clr) cnt <= '0;
    else cnt <= bit_done ? '0 : cnt + 1'b1;
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops FIFO entries one per frame and serialises each as an async UART frame on tx.
// Define FIFO_UART_PARITY_EN to insert an even-parity bit between the data and stop bits.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DATA_BITS    = 6,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tx_en,
  input  logic                 fifo_empty_n,
  input  logic [DATA_BITS-1:0] fifo_data,
  output logic                 fifo_pop,
  output logic                 tx,
  output logic                 busy
);
  localparam int IDX_W = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
  state_t               state;
  logic [DATA_BITS-1:0] shift;
  logic [IDX_W-1:0]     idx;
  logic                 bit_done;
  logic                 last_bit;
  logic                 go;
  assign fifo_pop = reset_n && state == SETTLE && fifo_empty_n;
  assign go       = fifo_empty_n && tx_en;
  assign last_bit = idx == IDX_W'(DATA_BITS - 1);
  // SETTLE always precedes START, so clearing there lines the timer up with the start bit
  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state == SETTLE),
    .bit_done(bit_done)
  );
`ifdef FIFO_UART_PARITY_EN
  logic par;
  always_ff @(posedge clk)
    if (!reset_n) par <= 1'b0;
    else if (fifo_pop) par <= even_parity(32'(fifo_data));
`endif
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      tx    <= TX_IDLE_LEVEL;
      busy  <= 1'b0;
      idx   <= '0;
      shift <= '0;
    end else begin
      case (state)
        IDLE: if (go) begin
          state <= SETTLE;
          busy  <= 1'b1;
        end
        SETTLE: if (fifo_empty_n) begin
          state <= START;
          shift <= fifo_data;
          tx    <= ~TX_IDLE_LEVEL;
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        START: if (bit_done) begin
          state <= DATA;
          idx   <= '0;
          tx    <= shift[0];
          shift <= shift >> 1;
        end
        DATA: if (bit_done) begin
          if (last_bit) begin
`ifdef FIFO_UART_PARITY_EN
            state <= PARITY;
            tx    <= par;
`else
            state <= STOP;
            tx    <= TX_IDLE_LEVEL;
`endif
          end else begin
            idx   <= idx + 1'b1;
            tx    <= shift[0];
            shift <= shift >> 1;
          end
        end
`ifdef FIFO_UART_PARITY_EN
        PARITY: if (bit_done) begin
          state <= STOP;
          tx    <= TX_IDLE_LEVEL;
        end
`endif
        STOP: if (bit_done) begin
          state <= go ? SETTLE : IDLE;
          busy  <= go;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed stimulus through a registered-FIFO model, frame-position reference model
module tb_fifo_uart_tx;
  localparam int DB  = 6;
  localparam int CPB = 4;
`ifdef FIFO_UART_PARITY_EN
  localparam int NB = DB + 3;
  localparam int HIGH_RUN = 2 * CPB + 1;
`else
  localparam int NB = DB + 2;
  localparam int HIGH_RUN = CPB + 1;
`endif
  localparam int FRAME = NB * CPB + 1;
  logic clk = 0, reset_n = 0, tx_en = 0, fifo_empty_n = 0;
  logic [DB-1:0] fifo_data = '0, head_d = '0;
  logic fifo_pop, tx, busy;
  int total = 0, bad = 0, cyc = 0, busy_cnt = 0;
  logic [DB-1:0] q[$];
  int pops[$];
  logic hist [0:8191];
  int pos = -1;
  logic [NB-1:0] frame;

  always #5 clk = ~clk;

  fifo_uart_tx #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .tx_en       (tx_en),
    .fifo_empty_n(fifo_empty_n),
    .fifo_data   (fifo_data),
    .fifo_pop    (fifo_pop),
    .tx          (tx),
    .busy        (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NB-1:0] make_frame(input logic [DB-1:0] d);
`ifdef FIFO_UART_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b1, d, 1'b0};
`endif
  endfunction

  function automatic int pop_at(input int i);
    return pops.size() > i ? pops[i] : 0;
  endfunction

  function automatic logic [31:0] mid_bit(input int p, input int b);
    return 32'(hist[(p + 1 + b * CPB + CPB / 2) % 8192]);
  endfunction

  function automatic logic [31:0] decode(input int p);
    logic [DB-1:0] d;
    for (int i = 0; i < DB; i++) d[i] = mid_bit(p, i + 1);
    return 32'(d);
  endfunction

  task automatic wait_pops(input int n);
    int k = 0;
    while (pops.size() < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (pops.size() < n) begin
      total++;
      bad++;
      $display("FAIL wait_pop: got %0d pops expected %0d", pops.size(), n);
    end
  endtask

  // registered FIFO: head data trails the non-empty flag and each pop by one clock
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_pop && q.size() != 0) void'(q.pop_front());
    fifo_empty_n <= q.size() != 0;
    fifo_data    <= head_d;
    head_d       <= q.size() != 0 ? q[0] : '0;
  end

  // reference: -1 idle, 0 settle cycle, 1..NB*CPB position inside the serial frame
  always @(posedge clk) begin
    if (!reset_n) pos = -1;
    else if (pos < 0) pos = (fifo_empty_n && tx_en) ? 0 : -1;
    else if (pos == 0) begin
      if (fifo_empty_n) begin
        frame = make_frame(fifo_data);
        pos = 1;
      end else pos = -1;
    end else if (pos == NB * CPB) pos = (fifo_empty_n && tx_en) ? 0 : -1;
    else pos++;
  end

  always @(negedge clk) begin
    if (cyc < 8192) hist[cyc] = tx;
    if (busy === 1'b1) busy_cnt++;
    if (fifo_pop === 1'b1) pops.push_back(cyc);
    if (cyc > 0) begin
      chk("tx", 32'(tx), pos < 1 ? 32'd1 : 32'(frame[(pos - 1) / CPB]));
      chk("busy", 32'(busy), 32'(pos >= 0));
      chk("pop", 32'(fifo_pop), 32'(pos == 0 && fifo_empty_n && reset_n));
    end
  end

  initial begin
    int p1, p2, n0, b0, run;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pop", 32'(fifo_pop), 0);
    reset_n = 1;
    tx_en = 1;
    // single frame 0x2D
    b0 = busy_cnt;
    n0 = pops.size();
    q.push_back(6'h2D);
    wait_pops(n0 + 1);
    p1 = pop_at(n0);
    repeat (FRAME + 6) @(negedge clk);
    chk("single_pops", 32'(pops.size() - n0), 1);
    chk("single_busy", 32'(busy_cnt - b0), 33 + (NB - 8) * CPB);
    chk("single_start", mid_bit(p1, 0), 0);
    chk("single_data", decode(p1), 6'h2D);
    chk("single_b1", mid_bit(p1, 1), 1);
    chk("single_b2", mid_bit(p1, 2), 0);
    chk("single_stop", mid_bit(p1, NB - 1), 1);
    // back-to-back 0x01, 0x3F
    n0 = pops.size();
    q.push_back(6'h01);
    q.push_back(6'h3F);
    wait_pops(n0 + 2);
    p1 = pop_at(n0);
    p2 = pop_at(n0 + 1);
    repeat (FRAME + 6) @(negedge clk);
    chk("b2b_gap", 32'(p2 - p1), FRAME);
    run = 0;
    for (int c = p2; c > p1 && hist[c % 8192] === 1'b1; c--) run++;
    chk("b2b_high", 32'(run), HIGH_RUN);
    chk("b2b_d0", decode(p1), 6'h01);
    chk("b2b_d1", decode(p2), 6'h3F);
    // stale head data for one cycle after the flag rises
    n0 = pops.size();
    q.push_back(6'h15);
    wait_pops(n0 + 1);
    repeat (FRAME + 6) @(negedge clk);
    chk("lag_data", decode(pop_at(n0)), 6'h15);
    // tx_en dropped mid-frame with FIFO still holding an entry
    n0 = pops.size();
    q.push_back(6'h2A);
    q.push_back(6'h33);
    wait_pops(n0 + 1);
    repeat (5) @(negedge clk);
    tx_en = 0;
    repeat (FRAME + 10) @(negedge clk);
    chk("en_pops", 32'(pops.size() - n0), 1);
    chk("en_busy", 32'(busy), 0);
    chk("en_tx", 32'(tx), 1);
    chk("en_left", 32'(q.size()), 1);
    chk("en_data", decode(pop_at(n0)), 6'h2A);
    tx_en = 1;
    wait_pops(n0 + 2);
    repeat (FRAME + 6) @(negedge clk);
    chk("en_data2", decode(pop_at(n0 + 1)), 6'h33);
    // reset mid-frame while the FIFO is non-empty
    n0 = pops.size();
    q.push_back(6'h0A);
    wait_pops(n0 + 1);
    repeat (8) @(negedge clk);
    reset_n = 0;
    q.push_back(6'h11);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mrst_tx", 32'(tx), 1);
      chk("mrst_busy", 32'(busy), 0);
      chk("mrst_pop", 32'(fifo_pop), 0);
    end
    chk("mrst_pops", 32'(pops.size() - n0), 1);
    reset_n = 1;
    wait_pops(n0 + 2);
    repeat (FRAME + 6) @(negedge clk);
    chk("mrst_data", decode(pop_at(n0 + 1)), 6'h11);
`ifdef FIFO_UART_PARITY_EN
    n0 = pops.size();
    q.push_back(6'h2D);
    q.push_back(6'h07);
    wait_pops(n0 + 2);
    p1 = pop_at(n0);
    p2 = pop_at(n0 + 1);
    repeat (FRAME + 6) @(negedge clk);
    chk("par_gap", 32'(p2 - p1), 37);
    chk("par_bit0", mid_bit(p1, DB + 1), 0);
    chk("par_bit1", mid_bit(p2, DB + 1), 1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Downstream drain stage for the 6-bit FIFO. It watches the FIFO's empty flag and registered head-data output, and pops one entry per frame. Each entry is serialised as an async UART frame on a single output pin. This lets the FIFO contents be streamed off-chip over one wire at a fixed clocks-per-bit rate.

Parameters:
DATA_BITS, 6, width of FIFO entry and of the UART data field.
CLKS_PER_BIT, 16, clock cycles per UART bit; legal range 2..65535.
DIV_W, $clog2(CLKS_PER_BIT), width of the bit-timer counter (derived, not overridden).

Ports:
clk  input  1  clock; all state changes on posedge.
reset_n  input  1  synchronous, active-low reset.
tx_en  input  1  permits starting new frames; sampled only in IDLE/STOP exit.
fifo_empty_n  input  1  FIFO non-empty flag.
fifo_data  input  DATA_BITS  FIFO head data, registered, valid one clock after fifo_empty_n first rises or after a pop.
fifo_pop  output  1  single-cycle pop strobe to the FIFO.
tx  output  1  UART serial line, idle high.
busy  output  1  high from SETTLE through end of STOP.

Behaviour:
- Reset (reset_n low at posedge): state=IDLE, tx=1, fifo_pop=0, busy=0, bit timer=0, bit index=0, shift reg=0. Takes effect mid-frame; the line returns high on the next edge.
- States: IDLE, SETTLE, START, DATA, PARITY (macro only), STOP.
- IDLE: tx=1. If fifo_empty_n && tx_en, go to SETTLE.
- SETTLE: lasts exactly one cycle, which absorbs the FIFO's one-cycle registered-data lag.
  - If fifo_empty_n is still 1: fifo_pop=1 this cycle; at the edge, shift <= fifo_data and go to START.
  - Otherwise: no pop; return to IDLE.
- fifo_pop is decoded from state and asserted only in SETTLE. It is never high in any other state or during reset.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: DATA_BITS bits, LSB first, each held CLKS_PER_BIT cycles. The shift register shifts right at each bit boundary.
- STOP: tx=1 for CLKS_PER_BIT cycles. On the last cycle:
  - if fifo_empty_n && tx_en, go to SETTLE;
  - else go to IDLE.
- Back-to-back frames: the stop bit is effectively CLKS_PER_BIT+1 cycles high (STOP plus SETTLE).
- Bit timer: counts 0..CLKS_PER_BIT-1 and wraps; the bit-done tick occurs at count CLKS_PER_BIT-1. The timer is cleared on entry to START.
- tx is driven from a register, so it is glitch-free.
- Frame length without the macro: (1+DATA_BITS+1)*CLKS_PER_BIT cycles, plus one SETTLE cycle.
- tx_en low mid-frame: the current frame completes; no new frame starts.
- FIFO empties during a frame: no effect on the frame. The block returns to IDLE after STOP.

Optional Feature:
FIFO_UART_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It sends the even-parity bit (XOR of the DATA_BITS captured bits) for CLKS_PER_BIT cycles. The parity is computed at capture time and stored in a one-bit register.
- Undefined: no PARITY state, no parity register; the frame goes DATA -> STOP.

Decomposition:
- Package fifo_uart_pkg:
  - state enum (IDLE, SETTLE, START, DATA, PARITY, STOP);
  - constant TX_IDLE_LEVEL=1;
  - function for even parity over DATA_BITS.
- One sub-module, uart_bit_timer: counter with clear and a bit_done tick output, parameterised by CLKS_PER_BIT.
- Shift register and FSM stay in the top module.

Test Plan:
- Reset: hold reset_n=0 for 3 clocks, including mid-frame -> tx=1, fifo_pop=0, busy=0 on the next edge; no pop is issued.
- Single frame (CLKS_PER_BIT=4, FIFO model loaded with 6'h2D) -> exactly one pop, in the cycle after SETTLE is entered. tx sequence, each bit 4 cycles: 0, 1,0,1,1,0,1, 1. busy is high 33 cycles.
- Back-to-back (FIFO holds 6'h01, 6'h3F) -> two pops 33 cycles apart; line high for 5 cycles between frames; second data field all 1s.
- Empty/lag check: fifo_empty_n rises with fifo_data=0 stale for one cycle, then 6'h15 -> transmitted value is 6'h15, not 0.
- tx_en dropped mid-frame with FIFO non-empty -> current frame finishes; no further pop; returns to IDLE with tx=1.
- FIFO_UART_PARITY_EN defined: send 6'h2D then 6'h07 -> parity bits 0 then 1; frame length 37 cycles each.
